img_writer: RTL and testbench
=============================

IMG_WRITER -- requirements
Module: img_writer

Interface
REQ-001 The block SHALL have these parameters:
- RGB_WIDTH, default 24: frame-buffer word width.
- DATA_WIDTH, default 8: per-channel width.
- IMG_WIDTH, default 80: pixels per line.
- IMG_HEIGHT, default 120: lines per frame.
- ADDR_WIDTH, default $clog2(IMG_WIDTH*IMG_HEIGHT): frame-buffer address width.

REQ-002 The block SHALL have these ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  reset, synchronous, active-high.
- start_write  in  1  single-cycle pulse; arms capture of one frame.
- i_de  in  1  input pixel valid.
- r_port, g_port, b_port  in  DATA_WIDTH each  pixel channels; valid when i_de=1.
- waddr  out  ADDR_WIDTH  frame-buffer write address.
- we  out  1  frame-buffer write enable.
- wdata  out  RGB_WIDTH  write data, {r,g,b}.
- busy  out  1  high in WRITE state.
- done  out  1  one-cycle pulse after the last pixel is written.
- drop_err  out  1  sticky: a pixel arrived while not armed.

Function
REQ-003 The FSM SHALL have three states: IDLE, WRITE, DONE.
REQ-004 Transitions:
- IDLE -> WRITE on start_write.
- WRITE -> DONE on acceptance of pixel (x=IMG_WIDTH-1, y=IMG_HEIGHT-1).
- DONE -> WRITE if start_write is high, else DONE -> IDLE; DONE lasts exactly one cycle.
REQ-005 start_write SHALL be ignored while in WRITE; counters are not cleared and no error is raised.
REQ-006 A pixel SHALL be accepted only when state=WRITE and i_de=1. No backpressure exists; every accepted pixel is written.
REQ-007 Counters x_cnt (0..IMG_WIDTH-1) and y_cnt (0..IMG_HEIGHT-1):
- Cleared to 0 on entry to WRITE.
- x_cnt increments per accepted pixel and wraps to 0 at IMG_WIDTH-1, at which point y_cnt increments.
- Counters hold while i_de=0, so gaps between pixels and lines are allowed.
REQ-008 Write outputs SHALL be registered, with one cycle of latency. In the cycle after acceptance: we=1, waddr=y_cnt*IMG_WIDTH+x_cnt (the values at acceptance), wdata={r_port,g_port,b_port} as sampled at acceptance.
REQ-009 When no pixel was accepted in the previous cycle, we SHALL be 0, and waddr and wdata SHALL be 0.
REQ-010 The address product SHALL be computed at ADDR_WIDTH or wider with no truncation; the maximum waddr is IMG_WIDTH*IMG_HEIGHT-1.
REQ-011 done SHALL be 1 exactly in the DONE-state cycle, which is the same cycle in which we=1 for the last pixel.
REQ-012 busy SHALL be 1 only in WRITE. In DONE it is 0, and in the following cycle it is 1 if a restart occurred.
REQ-013 drop_err SHALL be set when i_de=1 in IDLE or DONE. This includes the cycle in which start_write is accepted in IDLE; that pixel is dropped.
REQ-014 drop_err SHALL be cleared on the cycle after start_write is accepted, unless a new drop occurs in that same cycle.
REQ-015 Exactly IMG_WIDTH*IMG_HEIGHT writes SHALL be issued per frame. Pixels after the last one are dropped per REQ-013.

Reset
REQ-016 A synchronous reset SHALL force the following state regardless of current state, including mid-frame:
- state=IDLE, x_cnt=y_cnt=0.
- we=0, waddr=0, wdata=0.
- busy=0, done=0, drop_err=0.
REQ-017 A pixel accepted in the cycle reset is asserted SHALL NOT produce a write.
REQ-018 After reset, a new frame SHALL require a fresh start_write.

Verification (IMG_WIDTH=4, IMG_HEIGHT=2 unless noted)
REQ-019 Full frame: start_write, then 8 consecutive i_de pixels with value 0x000000+k -> we high 8 cycles; waddr 0..7; wdata k; done pulses with waddr=7; busy drops.
REQ-020 Gapped input: pixels with i_de toggling 1,0,1,0 and an idle gap between lines -> waddr sequence still 0..7, no duplicates or skips; done once.
REQ-021 Unarmed pixels: i_de=1 for 3 cycles in IDLE -> we stays 0; drop_err=1 and held; start_write -> drop_err=0 the next cycle.
REQ-022 Back-to-back frames: start_write asserted in the DONE cycle -> busy=1 next cycle; second frame waddr restarts at 0; no pixel lost.
REQ-023 Mid-frame reset: reset after 5 pixels -> all outputs 0, state IDLE; restart writes waddr from 0; done only after 8 new pixels.
REQ-024 Default parameters: full frame -> last waddr=9599, done coincident, ADDR_WIDTH=14, no address overflow.

Source files
------------

// File: rtl/img_writer.sv
// Frame-buffer writer: captures one armed frame of streamed RGB pixels and
// issues one registered write per pixel in raster order.
module img_writer #(
    parameter int RGB_WIDTH  = 24,
    parameter int DATA_WIDTH = 8,
    parameter int IMG_WIDTH  = 80,
    parameter int IMG_HEIGHT = 120,
    parameter int ADDR_WIDTH = $clog2(IMG_WIDTH * IMG_HEIGHT)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start_write,
    input  logic                  i_de,
    input  logic [DATA_WIDTH-1:0] r_port,
    input  logic [DATA_WIDTH-1:0] g_port,
    input  logic [DATA_WIDTH-1:0] b_port,
    output logic [ADDR_WIDTH-1:0] waddr,
    output logic                  we,
    output logic [RGB_WIDTH-1:0]  wdata,
    output logic                  busy,
    output logic                  done,
    output logic                  drop_err
);

    localparam int XW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam int YW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t                  state_r;
    state_t                  state_next_s;
    logic [XW-1:0]           x_cnt_r;
    logic [XW-1:0]           x_cnt_next_s;
    logic [YW-1:0]           y_cnt_r;
    logic [YW-1:0]           y_cnt_next_s;
    logic                    accept_s;
    logic                    x_last_s;
    logic                    y_last_s;
    logic                    start_acc_s;
    logic                    drop_s;
    logic                    drop_next_s;
    logic [ADDR_WIDTH-1:0]   waddr_r;
    logic                    we_r;
    logic [RGB_WIDTH-1:0]    wdata_r;
    logic                    busy_r;
    logic                    done_r;
    logic                    drop_err_r;

    // Raster address; operands are widened before the multiply so nothing truncates.
    function automatic logic [ADDR_WIDTH-1:0] pix_addr(input logic [XW-1:0] x,
                                                      input logic [YW-1:0] y);
        pix_addr = ADDR_WIDTH'(y) * ADDR_WIDTH'(IMG_WIDTH) + ADDR_WIDTH'(x);
    endfunction

    // Acceptance, drop detection and counter/state next-value logic.
    always_comb begin
        accept_s     = (state_r == ST_WRITE) && i_de;
        x_last_s     = (x_cnt_r == XW'(IMG_WIDTH - 1));
        y_last_s     = (y_cnt_r == YW'(IMG_HEIGHT - 1));
        start_acc_s  = start_write && (state_r != ST_WRITE);
        drop_s       = i_de && (state_r != ST_WRITE);
        state_next_s = state_r;
        x_cnt_next_s = x_cnt_r;
        y_cnt_next_s = y_cnt_r;
        drop_next_s  = drop_err_r;

        case (state_r)
            ST_IDLE: begin
                if (start_write) begin
                    state_next_s = ST_WRITE;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_WRITE: begin
                if (accept_s && x_last_s && y_last_s) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_WRITE;
                end
            end
            ST_DONE: begin
                if (start_write) begin
                    state_next_s = ST_WRITE;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase

        if (start_acc_s) begin
            x_cnt_next_s = '0;
            y_cnt_next_s = '0;
        end else if (accept_s) begin
            if (x_last_s) begin
                x_cnt_next_s = '0;
                if (y_last_s) begin
                    y_cnt_next_s = '0;
                end else begin
                    y_cnt_next_s = y_cnt_r + YW'(1);
                end
            end else begin
                x_cnt_next_s = x_cnt_r + XW'(1);
                y_cnt_next_s = y_cnt_r;
            end
        end else begin
            x_cnt_next_s = x_cnt_r;
            y_cnt_next_s = y_cnt_r;
        end

        // A drop in the arming cycle itself keeps the flag set.
        if (drop_s) begin
            drop_next_s = 1'b1;
        end else if (start_acc_s) begin
            drop_next_s = 1'b0;
        end else begin
            drop_next_s = drop_err_r;
        end
    end

    // State, counters and all registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            x_cnt_r    <= '0;
            y_cnt_r    <= '0;
            we_r       <= 1'b0;
            waddr_r    <= '0;
            wdata_r    <= '0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            drop_err_r <= 1'b0;
        end else begin
            state_r    <= state_next_s;
            x_cnt_r    <= x_cnt_next_s;
            y_cnt_r    <= y_cnt_next_s;
            we_r       <= accept_s;
            waddr_r    <= accept_s ? pix_addr(x_cnt_r, y_cnt_r) : '0;
            wdata_r    <= accept_s ? RGB_WIDTH'({r_port, g_port, b_port}) : '0;
            busy_r     <= (state_next_s == ST_WRITE);
            done_r     <= (state_next_s == ST_DONE);
            drop_err_r <= drop_next_s;
        end
    end

    assign waddr    = waddr_r;
    assign we       = we_r;
    assign wdata    = wdata_r;
    assign busy     = busy_r;
    assign done     = done_r;
    assign drop_err = drop_err_r;

endmodule

// File: tb/tb_img_writer.sv
// Scoreboard bench for img_writer: a small 4x2 instance for protocol cases and
// a default-size instance for the full-resolution address range.
module tb_img_writer;

    localparam int W = 4;
    localparam int H = 2;
    localparam int S_ID = 0;
    localparam int S_WR = 1;
    localparam int S_DN = 2;

    typedef struct {
        int          addr;
        logic [23:0] data;
        bit          last;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start_write = 1'b0;
    logic        i_de = 1'b0;
    logic [7:0]  r_port = 8'd0;
    logic [7:0]  g_port = 8'd0;
    logic [7:0]  b_port = 8'd0;
    logic [2:0]  waddr;
    logic        we;
    logic [23:0] wdata;
    logic        busy;
    logic        done;
    logic        drop_err;

    logic        st2 = 1'b0;
    logic        de2 = 1'b0;
    logic [7:0]  r2 = 8'd0;
    logic [7:0]  g2 = 8'd0;
    logic [7:0]  b2 = 8'd0;
    logic [13:0] waddr2;
    logic        we2;
    logic [23:0] wdata2;
    logic        busy2;
    logic        done2;
    logic        drop2;

    int   n_chk = 0;
    int   n_pass = 0;
    int   m_state = S_ID;
    int   m_x = 0;
    int   m_y = 0;
    bit   m_drop = 1'b0;
    exp_t sb[$];

    img_writer #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .clk(clk), .reset(reset), .start_write(start_write), .i_de(i_de),
        .r_port(r_port), .g_port(g_port), .b_port(b_port),
        .waddr(waddr), .we(we), .wdata(wdata), .busy(busy), .done(done),
        .drop_err(drop_err)
    );

    img_writer dut_def (
        .clk(clk), .reset(reset), .start_write(st2), .i_de(de2),
        .r_port(r2), .g_port(g2), .b_port(b2),
        .waddr(waddr2), .we(we2), .wdata(wdata2), .busy(busy2), .done(done2),
        .drop_err(drop2)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock of stimulus: update the reference model, clock, then compare.
    task automatic step(input logic sw, input logic de, input logic [23:0] pix);
        bit   acc;
        bit   sacc;
        exp_t e;
        start_write = sw;
        i_de = de;
        {r_port, g_port, b_port} = pix;
        acc  = (m_state == S_WR) && de;
        sacc = sw && (m_state != S_WR);
        if (acc) begin
            e.addr = m_y * W + m_x;
            e.data = pix;
            e.last = (m_x == W - 1) && (m_y == H - 1);
            sb.push_back(e);
        end
        if (de && m_state != S_WR) m_drop = 1'b1;
        else if (sacc) m_drop = 1'b0;
        case (m_state)
            S_ID:    m_state = sw ? S_WR : S_ID;
            S_WR:    m_state = (acc && e.last) ? S_DN : S_WR;
            default: m_state = sw ? S_WR : S_ID;
        endcase
        if (sacc) begin
            m_x = 0;
            m_y = 0;
        end else if (acc) begin
            if (m_x == W - 1) begin
                m_x = 0;
                m_y = (m_y == H - 1) ? 0 : m_y + 1;
            end else begin
                m_x = m_x + 1;
            end
        end
        @(posedge clk);
        #1;
        check_val("we", 32'(we), 32'(acc));
        if (acc) begin
            e = sb.pop_front();
            check_val("waddr", 32'(waddr), 32'(e.addr));
            check_val("wdata", 32'(wdata), 32'(e.data));
            check_val("done_last", 32'(done), 32'(e.last));
        end else begin
            check_val("waddr_idle", 32'(waddr), 32'd0);
            check_val("wdata_idle", 32'(wdata), 32'd0);
        end
        check_val("busy", 32'(busy), 32'(m_state == S_WR));
        check_val("done", 32'(done), 32'(m_state == S_DN));
        check_val("drop_err", 32'(drop_err), 32'(m_drop));
    endtask

    // Synchronous reset for one cycle, optionally with a pixel presented.
    task automatic do_reset(input logic de);
        reset = 1'b1;
        start_write = 1'b0;
        i_de = de;
        {r_port, g_port, b_port} = 24'hABCDEF;
        @(posedge clk);
        #1;
        reset = 1'b0;
        i_de = 1'b0;
        m_state = S_ID;
        m_x = 0;
        m_y = 0;
        m_drop = 1'b0;
        sb.delete();
        check_val("rst_we", 32'(we), 32'd0);
        check_val("rst_waddr", 32'(waddr), 32'd0);
        check_val("rst_wdata", 32'(wdata), 32'd0);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_done", 32'(done), 32'd0);
        check_val("rst_drop", 32'(drop_err), 32'd0);
    endtask

    initial begin
        int nwr;
        int ndone;
        int last_addr;
        int last_data;
        int done_we;
        int max_addr;

        @(posedge clk);
        #1;
        do_reset(1'b0);

        // Full frame with value k at pixel k, then idle.
        step(1'b1, 1'b0, 24'd0);
        for (int k = 0; k < W * H; k++) step(1'b0, 1'b1, 24'(k));
        step(1'b0, 1'b0, 24'd0);
        step(1'b0, 1'b0, 24'd0);

        // Gapped input, a line gap, an ignored start_write mid-frame, a drop in DONE.
        step(1'b1, 1'b0, 24'd0);
        for (int k = 0; k < W * H; k++) begin
            step((k == 5) ? 1'b1 : 1'b0, 1'b1, 24'h100000 + 24'(k));
            step(1'b0, 1'b0, 24'd0);
            if (k == W - 1) begin
                for (int g = 0; g < 3; g++) step(1'b0, 1'b0, 24'd0);
            end
        end
        for (int k = 0; k < W * H - 1; k++) step(1'b0, (k % 2 == 0) ? 1'b1 : 1'b0, 24'h200000 + 24'(k));
        step(1'b1, 1'b0, 24'd0);
        for (int k = 0; k < W * H; k++) step(1'b0, 1'b1, 24'h300000 + 24'(k));
        step(1'b0, 1'b1, 24'hDEAD00);
        step(1'b0, 1'b0, 24'd0);

        // Unarmed pixels hold drop_err until the next start_write.
        for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 24'h400000 + 24'(k));
        step(1'b0, 1'b0, 24'd0);
        step(1'b1, 1'b0, 24'd0);
        for (int k = 0; k < W * H; k++) step(1'b0, 1'b1, 24'($urandom));

        // Back-to-back restart from DONE.
        step(1'b1, 1'b0, 24'd0);
        for (int k = 0; k < W * H; k++) step(1'b0, 1'b1, 24'($urandom));
        step(1'b0, 1'b0, 24'd0);

        // Mid-frame reset with a pixel in the reset cycle, then a fresh frame.
        step(1'b1, 1'b0, 24'd0);
        for (int k = 0; k < 5; k++) step(1'b0, 1'b1, 24'h500000 + 24'(k));
        do_reset(1'b1);
        step(1'b0, 1'b0, 24'd0);
        step(1'b1, 1'b0, 24'd0);
        for (int k = 0; k < W * H; k++) begin
            step(1'b0, 1'b1, 24'h600000 + 24'(k));
            if (k == 2) step(1'b0, 1'b0, 24'd0);
        end
        step(1'b0, 1'b0, 24'd0);
        check_val("sb_drained", 32'(sb.size()), 32'd0);

        // Default-size frame.
        nwr = 0;
        ndone = 0;
        last_addr = -1;
        last_data = -1;
        done_we = 0;
        max_addr = 0;
        st2 = 1'b1;
        @(posedge clk);
        #1;
        st2 = 1'b0;
        for (int c = 0; c < 9700; c++) begin
            de2 = (c < 9600) ? 1'b1 : 1'b0;
            {r2, g2, b2} = 24'(c);
            @(posedge clk);
            #1;
            if (we2) begin
                nwr++;
                if (int'(waddr2) > max_addr) max_addr = int'(waddr2);
            end
            if (done2) begin
                ndone++;
                last_addr = int'(waddr2);
                last_data = int'(wdata2);
                done_we = int'(we2);
            end
        end
        check_val("def_writes", 32'(nwr), 32'd9600);
        check_val("def_done_cnt", 32'(ndone), 32'd1);
        check_val("def_last_addr", 32'(last_addr), 32'd9599);
        check_val("def_last_data", 32'(last_data), 32'd9599);
        check_val("def_done_we", 32'(done_we), 32'd1);
        check_val("def_max_addr", 32'(max_addr), 32'd9599);
        check_val("def_busy_end", 32'(busy2), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
